// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V instruction fetch path.
package riscv_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

  // Misalignment wins over range so a wild unaligned pointer reports as misaligned.
  function automatic logic [1:0] classify_fault(input logic misaligned,
                                                input logic out_of_range);
    if (misaligned)   return FAULT_MISALIGN;
    if (out_of_range) return FAULT_RANGE;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry in-order response buffer; the head entry is always on o_data.
module imem_rsp_fifo
  import riscv_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  fifo_state_e r_state;
  logic [W-1:0] r_ent0;
  logic [W-1:0] r_ent1;
  logic         w_pop;

  assign w_pop   = (r_state != FIFO_EMPTY) && i_pop_ready;
  assign o_valid = (r_state != FIFO_EMPTY);
  assign o_data  = r_ent0;
  assign o_count = r_state;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FIFO_EMPTY;
      r_ent0  <= '0;
      r_ent1  <= '0;
    end else begin
      unique case (r_state)
        FIFO_EMPTY: begin
          if (i_push) begin
            r_ent0  <= i_push_data;
            r_state <= FIFO_ONE;
          end
        end
        FIFO_ONE: begin
          unique case ({i_push, w_pop})
            2'b10: begin
              r_ent1  <= i_push_data;
              r_state <= FIFO_FULL;
            end
            2'b01: r_state <= FIFO_EMPTY;
            2'b11: r_ent0  <= i_push_data;
            default: ;
          endcase
        end
        FIFO_FULL: begin
          // Pushes are never offered when full; only a pop moves us on.
          if (w_pop) begin
            r_ent0  <= r_ent1;
            r_state <= FIFO_ONE;
          end
        end
        default: r_state <= FIFO_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/imem_port.sv
// Instruction memory with valid/ready fetch port, fault decode, program-load port and fetch counter.
module imem_port
  import riscv_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [1:0]               rsp_fault,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [DATA_W-1:0]        ld_data,
  output logic [31:0]              fetch_cnt
);

  localparam int              IDX_W       = $clog2(DEPTH);
  localparam logic [ADDR_W:0] RANGE_BYTES = (ADDR_W+1)'(DEPTH) << 2;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [31:0]       r_fetch_cnt;

  logic [ADDR_W-1:0] w_offset;
  logic [IDX_W-1:0]  w_idx;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic [1:0]        w_fault;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_push;
  logic [1:0]        w_count;
  logic [DATA_W+1:0] w_head;

  assign w_offset       = req_addr - BASE_ADDR;
  assign w_idx          = w_offset[IDX_W+1:2];
  assign w_misaligned   = |req_addr[1:0];
  // The wide compare keeps DEPTH*4 representable even when it equals 2^ADDR_W.
  assign w_out_of_range = (req_addr < BASE_ADDR) || ({1'b0, w_offset} >= RANGE_BYTES);
  assign w_fault        = classify_fault(w_misaligned, w_out_of_range);
  assign w_rd_word      = (w_fault == FAULT_NONE) ? r_mem[w_idx] : DATA_W'(INST_NOP);

  assign req_ready = rst_n && !ld_en && (w_count < 2'd2);
  assign w_push    = req_valid && req_ready;

  // NOTE: the array has no reset branch; a reset would turn the RAM into a bank of flops.
  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_idx] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      r_fetch_cnt <= '0;
    else if (w_push) r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end

  assign fetch_cnt = r_fetch_cnt;

  imem_rsp_fifo #(
    .W (DATA_W + 2)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data ({w_fault, w_rd_word}),
    .i_pop_ready (rsp_ready),
    .o_valid     (rsp_valid),
    .o_data      (w_head),
    .o_count     (w_count)
  );

  assign rsp_fault = w_head[DATA_W+1:DATA_W];
  assign rsp_data  = w_head[DATA_W-1:0];

endmodule

// File: tb/tb_imem_port.sv
// Directed bench for imem_port: streaming, backpressure, faults, load/fetch, reset, non-zero base.
module tb_imem_port;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, ld_en;
  logic [31:0] req_addr, rsp_data, ld_data, fetch_cnt;
  logic [1:0]  rsp_fault;
  logic [7:0]  ld_idx;

  logic        h_req_valid, h_req_ready, h_rsp_valid, h_rsp_ready, h_ld_en;
  logic [31:0] h_req_addr, h_rsp_data, h_ld_data, h_fetch_cnt;
  logic [1:0]  h_rsp_fault;
  logic [7:0]  h_ld_idx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imem_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data), .fetch_cnt(fetch_cnt)
  );

  imem_port #(.BASE_ADDR(32'h8000_0000)) dut_hi (
    .clk(clk), .rst_n(rst_n),
    .req_valid(h_req_valid), .req_ready(h_req_ready), .req_addr(h_req_addr),
    .rsp_valid(h_rsp_valid), .rsp_ready(h_rsp_ready), .rsp_data(h_rsp_data), .rsp_fault(h_rsp_fault),
    .ld_en(h_ld_en), .ld_idx(h_ld_idx), .ld_data(h_ld_data), .fetch_cnt(h_fetch_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated fetch; the response is left at the head and popped by the next edge.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                       input logic [1:0] exp_fault, input string tag);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    check({tag, "_ready"}, req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    #1;
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_data"},  rsp_data,  exp_data);
    check({tag, "_fault"}, rsp_fault, exp_fault);
  endtask

  logic [7:0]  ld_tbl_idx  [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd255};
  logic [31:0] ld_tbl_data [6] = '{32'h13, 32'h13, 32'h0340_0093,
                                   32'hAAAA_0001, 32'hBBBB_0002, 32'h5A5A_5A5A};
  logic [31:0] stream_exp  [3] = '{32'h13, 32'h13, 32'h0340_0093};

  logic [31:0] hi_addr  [3] = '{32'h8000_0008, 32'h7FFF_FFFC, 32'h8000_0400};
  logic [31:0] hi_data  [3] = '{32'h0BAD_F00D, 32'h13, 32'h13};
  logic [1:0]  hi_fault [3] = '{2'b00, 2'b10, 2'b10};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    h_req_valid = 1'b0; h_req_addr = '0; h_rsp_ready = 1'b0;
    h_ld_en = 1'b0; h_ld_idx = '0; h_ld_data = '0;

    tick();
    tick();
    req_valid = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data",  rsp_data,  32'h0);
    check("rst_rsp_fault", rsp_fault, 2'b00);
    check("rst_fetch_cnt", fetch_cnt, 32'h0);
    check("rst_hi_valid",  h_rsp_valid, 1'b0);
    rst_n = 1'b1;

    // Program load with a fetch pending: the load must block acceptance.
    req_addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      ld_en = 1'b1; ld_idx = ld_tbl_idx[i]; ld_data = ld_tbl_data[i];
      #1;
      if (i == 0) check("ld_blocks_req", req_ready, 1'b0);
      tick();
    end
    ld_en = 1'b0;
    req_valid = 1'b0;
    #1;
    check("ld_no_accept_cnt", fetch_cnt, 32'd0);

    // Back-to-back streaming with the consumer always ready.
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(i * 4);
      #1;
      check("stream_ready", req_ready, 1'b1);
      if (i > 0) begin
        check("stream_valid", rsp_valid, 1'b1);
        check("stream_data",  rsp_data,  {32'h0, stream_exp[i-1]});
      end
      tick();
    end
    req_valid = 1'b0;
    #1;
    check("stream_last_data",  rsp_data,  stream_exp[2]);
    check("stream_last_fault", rsp_fault, 2'b00);
    check("stream_cnt",        fetch_cnt, 32'd3);
    tick();
    check("stream_drained", rsp_valid, 1'b0);

    // Backpressure: two accepted, third waits for the first pop.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_addr = 32'hC;
    #1;
    check("bp_ready_2nd", req_ready, 1'b1);
    tick();
    req_addr = 32'h10;
    #1;
    check("bp_full_ready", req_ready, 1'b0);
    tick();
    check("bp_hold_ready", req_ready, 1'b0);
    check("bp_hold_data",  rsp_data,  32'h0340_0093);
    check("bp_hold_cnt",   fetch_cnt, 32'd5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    check("bp_ready_back", req_ready, 1'b1);
    check("bp_pop1_data",  rsp_data,  32'hAAAA_0001);
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("bp_third_cnt", fetch_cnt, 32'd6);
    check("bp_order2",    rsp_data,  32'hAAAA_0001);
    tick();
    check("bp_order3", rsp_data, 32'hBBBB_0002);
    tick();
    check("bp_drained", rsp_valid, 1'b0);

    // Fault classification and the top word of the array.
    fetch(32'h0000_0002, INST_NOP, FAULT_MISALIGN, "flt_mis");
    fetch(32'h0000_0400, INST_NOP, FAULT_RANGE,    "flt_range");
    fetch(32'h0000_0402, INST_NOP, FAULT_MISALIGN, "flt_prio");
    fetch(32'h0000_03FC, 32'h5A5A_5A5A, FAULT_NONE, "flt_top_word");
    tick();
    check("flt_cnt", fetch_cnt, 32'd10);

    // Load then fetch the same word on the following cycle.
    ld_en = 1'b1; ld_idx = 8'd5; ld_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_addr = 32'h14;
    #1;
    check("ldf_blocked", req_ready, 1'b0);
    tick();
    ld_en = 1'b0;
    fetch(32'h14, 32'hDEAD_BEEF, FAULT_NONE, "ldf_new");
    tick();
    check("ldf_cnt", fetch_cnt, 32'd11);

    // Reset with the buffer full: everything buffered is discarded.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_addr = 32'h4;
    tick();
    req_addr = 32'h8;
    #1;
    check("mid_full", req_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("mid_valid", rsp_valid, 1'b0);
    check("mid_cnt",   fetch_cnt, 32'd0);
    check("mid_data",  rsp_data,  32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_stale", rsp_valid, 1'b0);
    end

    // Non-zero base address instance.
    h_ld_en = 1'b1; h_ld_idx = 8'd2; h_ld_data = 32'h0BAD_F00D;
    tick();
    h_ld_en = 1'b0;
    h_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      h_req_valid = 1'b1;
      h_req_addr  = hi_addr[i];
      #1;
      check("hi_ready", h_req_ready, 1'b1);
      tick();
      h_req_valid = 1'b0;
      #1;
      check("hi_valid", h_rsp_valid, 1'b1);
      check("hi_data",  h_rsp_data,  hi_data[i]);
      check("hi_fault", h_rsp_fault, hi_fault[i]);
    end
    tick();
    check("hi_cnt", h_fetch_cnt, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
